// File: rtl/dmem_pkg.sv
// Shared constants for the data memory and its two requesters.
package dmem_pkg;

   localparam int DMEM_WORDS = 4096;

   localparam logic [3:0] WE_NONE = 4'h0;
   localparam logic [3:0] WE_WORD = 4'hF;

   // Port index 0 is the CPU data port, 1 is the host/DMA loader.
   localparam logic PORT_CPU  = 1'b0;
   localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/rr_grant2.sv
// Combinational two-way round-robin picker; burst hold lets the last owner
// keep the grant while its burst allowance lasts.
module rr_grant2
   import dmem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   input  logic       hold_ok,
   output logic [1:0] gnt
);

   logic winner;

   always_comb begin
      winner = PORT_CPU;
      gnt    = 2'b00;
      case (req)
         2'b01: gnt = 2'b01;
         2'b10: gnt = 2'b10;
         2'b11: begin
            // Under contention the other port wins unless a burst is still running.
            winner = hold_ok ? last_owner : ~last_owner;
            gnt    = (winner == PORT_HOST) ? 2'b10 : 2'b01;
         end
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported dmem between the CPU (port 0) and host loader (port 1)
// with round-robin grants, bounded bursts and a fixed one-cycle response.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter  int ADDR_W    = 32,
   parameter  int MAX_BURST = 4,
   localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [31:0]       wdata0,
   input  logic [31:0]       wdata1,
   input  logic [3:0]        we0,
   input  logic [3:0]        we1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [31:0]       rdata0,
   output logic [31:0]       rdata1,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_d,
   output logic [3:0]        mem_we,
   input  logic [31:0]       mem_q
);

   localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic             last_owner;
   logic [CNT_W-1:0] burst_cnt;
   logic             rsp_valid;
   logic             rsp_owner;

   logic [1:0]       req_vec;
   logic [1:0]       gnt_vec;
   logic             hold_ok;
   logic             any_gnt;
   logic             gnt_port;
   logic             continuing;
   logic [CNT_W-1:0] burst_next;

   // Requests are masked while in reset so nothing reaches dmem.
   assign req_vec = {req1 & rst_n, req0 & rst_n};

   // A nonzero count means the last owner was granted in the previous cycle,
   // since any idle cycle clears it.
   assign hold_ok = (burst_cnt != '0) && (burst_cnt < BURST_LIMIT);

   rr_grant2 u_pick (
      .req        (req_vec),
      .last_owner (last_owner),
      .hold_ok    (hold_ok),
      .gnt        (gnt_vec)
   );

   assign gnt0     = gnt_vec[0];
   assign gnt1     = gnt_vec[1];
   assign any_gnt  = gnt0 | gnt1;
   assign gnt_port = gnt1 ? PORT_HOST : PORT_CPU;

   always_comb begin
      mem_en   = 1'b0;
      mem_addr = '0;
      mem_d    = '0;
      mem_we   = WE_NONE;
      if (gnt0) begin
         mem_en   = 1'b1;
         mem_addr = addr0;
         mem_d    = wdata0;
         mem_we   = we0;
      end else if (gnt1) begin
         mem_en   = 1'b1;
         mem_addr = addr1;
         mem_d    = wdata1;
         mem_we   = we1;
      end
   end

   always_comb begin
      continuing = (gnt_port == last_owner) && (burst_cnt != '0);
      burst_next = CNT_ONE;
      if (continuing) begin
         burst_next = (burst_cnt >= BURST_LIMIT) ? BURST_LIMIT : burst_cnt + CNT_ONE;
      end
   end

   // Reset leaves port 1 as last owner so port 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_owner <= PORT_HOST;
         burst_cnt  <= '0;
         rsp_valid  <= 1'b0;
         rsp_owner  <= PORT_CPU;
      end else if (any_gnt) begin
         last_owner <= gnt_port;
         burst_cnt  <= burst_next;
         rsp_valid  <= 1'b1;
         rsp_owner  <= gnt_port;
      end else begin
         burst_cnt  <= '0;
         rsp_valid  <= 1'b0;
      end
   end

   assign rvalid0 = rsp_valid && (rsp_owner == PORT_CPU);
   assign rvalid1 = rsp_valid && (rsp_owner == PORT_HOST);
   assign rdata0  = rvalid0 ? mem_q : 32'h0;
   assign rdata1  = rvalid1 ? mem_q : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural dmem and a response scoreboard.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int ADDR_W    = 32;
   localparam int MAX_BURST = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req0 = 1'b0, req1 = 1'b0;
   logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
   logic [31:0]       wdata0 = '0, wdata1 = '0;
   logic [3:0]        we0 = WE_NONE, we1 = WE_NONE;
   logic              gnt0, gnt1, rvalid0, rvalid1;
   logic [31:0]       rdata0, rdata1;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_d;
   logic [3:0]        mem_we;
   logic [31:0]       mem_q = '0;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        port;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem[DMEM_WORDS];
   logic [31:0] ref_mem[DMEM_WORDS];

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_d(mem_d), .mem_we(mem_we),
      .mem_q(mem_q)
   );

   function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] we);
      logic [31:0] w;
      w = old;
      for (int b = 0; b < 4; b++) begin
         if (we[b]) w[b*8 +: 8] = d[b*8 +: 8];
      end
      return w;
   endfunction

   function automatic logic [31:0] init_word(input int i);
      return (i == 3) ? 32'h11223344 : (32'hA5000000 | 32'(i));
   endfunction

   // Behavioural dmem: registered, merged-word output the cycle after en.
   always @(posedge clk) begin
      if (mem_en) begin
         mem[mem_addr[11:0]] <= merge_word(mem[mem_addr[11:0]], mem_d, mem_we);
         mem_q               <= merge_word(mem[mem_addr[11:0]], mem_d, mem_we);
      end
   end

   initial begin
      for (int i = 0; i < DMEM_WORDS; i++) mem[i] = init_word(i);
   end

   // Scoreboard: expected responses pushed on grant, popped one cycle later.
   initial begin
      exp_t        e;
      logic        p;
      logic [11:0] a;
      for (int i = 0; i < DMEM_WORDS; i++) ref_mem[i] = init_word(i);
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            total++;
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
               bad++;
               $display("[TB] FAIL sb_reset_rvalid: got %b%b expected 00", rvalid1, rvalid0);
            end
            exp_q.delete();
         end else begin
            total++;
            if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
               bad++;
               $display("[TB] FAIL sb_gnt_exclusive: got 11 expected at most one grant");
            end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               total++;
               if (e.port == PORT_CPU) begin
                  if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata0 !== e.data || rdata1 !== 32'h0) begin
                     bad++;
                     $display("[TB] FAIL sb_rsp0: got rv=%b%b rd0=%h rd1=%h expected rv=01 rd0=%h rd1=0",
                              rvalid1, rvalid0, rdata0, rdata1, e.data);
                  end
               end else begin
                  if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata1 !== e.data || rdata0 !== 32'h0) begin
                     bad++;
                     $display("[TB] FAIL sb_rsp1: got rv=%b%b rd1=%h rd0=%h expected rv=10 rd1=%h rd0=0",
                              rvalid1, rvalid0, rdata1, rdata0, e.data);
                  end
               end
            end else begin
               total++;
               if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
                  bad++;
                  $display("[TB] FAIL sb_no_rsp: got rv=%b%b rd0=%h rd1=%h expected all 0",
                           rvalid1, rvalid0, rdata0, rdata1);
               end
            end
            if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
               p = (gnt1 === 1'b1);
               a = p ? addr1[11:0] : addr0[11:0];
               ref_mem[a] = merge_word(ref_mem[a], p ? wdata1 : wdata0, p ? we1 : we0);
               e.port = p;
               e.data = ref_mem[a];
               exp_q.push_back(e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected test completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req0(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      req0 = r; addr0 = a; wdata0 = d; we0 = w;
   endtask

   task automatic set_req1(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      req1 = r; addr1 = a; wdata1 = d; we1 = w;
   endtask

   task automatic reset_dut();
      set_req0(1'b0, 0, 0, WE_NONE);
      set_req1(1'b0, 0, 0, WE_NONE);
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_req0(1'b1, 5, 0, WE_NONE);
      set_req1(1'b1, 9, 0, WE_NONE);
      @(negedge clk);
      total++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_en !== 1'b0 || mem_addr !== '0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got gnt=%b%b en=%b addr=%h expected 00 0 0",
                  gnt1, gnt0, mem_en, mem_addr);
      end
   endtask

   task automatic test_first_contention();
      step();
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_addr !== 32'd5) begin
         bad++;
         $display("[TB] FAIL first_gnt: got gnt=%b%b addr=%h expected 01 addr=5", gnt1, gnt0, mem_addr);
      end
      step();
      set_req0(1'b0, 0, 0, WE_NONE);
      set_req1(1'b0, 0, 0, WE_NONE);
      @(negedge clk);
      total++;
      if (rvalid0 !== 1'b1 || rdata0 !== 32'hA5000005) begin
         bad++;
         $display("[TB] FAIL first_rsp: got rv0=%b rd0=%h expected 1 a5000005", rvalid0, rdata0);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g;
      reset_dut();
      set_req0(1'b1, 20, 0, WE_NONE);
      set_req1(1'b1, 21, 0, WE_NONE);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         exp_g = ((i % 8) < 4) ? 2'b01 : 2'b10;
         total++;
         if ({gnt1, gnt0} !== exp_g) begin
            bad++;
            $display("[TB] FAIL rr_seq[%0d]: got %b expected %b", i, {gnt1, gnt0}, exp_g);
         end
         step();
      end
      set_req0(1'b0, 0, 0, WE_NONE);
      set_req1(1'b0, 0, 0, WE_NONE);
      step();
   endtask

   task automatic test_write();
      reset_dut();
      set_req1(1'b1, 3, 32'hAABBCCDD, 4'b0011);
      @(negedge clk);
      total++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_en !== 1'b1 || mem_we !== 4'b0011 ||
          mem_addr !== 32'd3 || mem_d !== 32'hAABBCCDD) begin
         bad++;
         $display("[TB] FAIL write_issue: got gnt=%b%b en=%b we=%b addr=%h d=%h expected 10 1 0011 3 aabbccdd",
                  gnt1, gnt0, mem_en, mem_we, mem_addr, mem_d);
      end
      step();
      set_req1(1'b0, 0, 0, WE_NONE);
      @(negedge clk);
      total++;
      if (rvalid1 !== 1'b1 || rdata1 !== 32'h1122CCDD) begin
         bad++;
         $display("[TB] FAIL write_rsp: got rv1=%b rd1=%h expected 1 1122ccdd", rvalid1, rdata1);
      end
      step();
   endtask

   task automatic test_saturation();
      reset_dut();
      set_req0(1'b1, 40, 0, WE_NONE);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sat_gnt[%0d]: got %b%b expected 01", i, gnt1, gnt0);
         end
         step();
      end
      total++;
      if (dut.burst_cnt !== 3'd4) begin
         bad++;
         $display("[TB] FAIL sat_cnt: got %0d expected 4", dut.burst_cnt);
      end
      set_req1(1'b1, 41, 0, WE_NONE);
      @(negedge clk);
      total++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL sat_handover: got %b%b expected 10", gnt1, gnt0);
      end
      step();
      set_req0(1'b0, 0, 0, WE_NONE);
      set_req1(1'b0, 0, 0, WE_NONE);
      step();
   endtask

   task automatic test_reset_mid();
      reset_dut();
      set_req1(1'b1, 7, 0, WE_NONE);
      @(negedge clk);
      total++;
      if (gnt1 !== 1'b1) begin
         bad++;
         $display("[TB] FAIL mid_gnt1: got %b expected 1", gnt1);
      end
      step();
      set_req1(1'b0, 0, 0, WE_NONE);
      #1;
      total++;
      if (rvalid1 !== 1'b1) begin
         bad++;
         $display("[TB] FAIL mid_rv1_before: got %b expected 1", rvalid1);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (rvalid1 !== 1'b0 || rvalid0 !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL mid_async_clear: got rv=%b%b gnt=%b%b expected 00 00", rvalid1, rvalid0, gnt1, gnt0);
      end
      set_req0(1'b1, 8, 0, WE_NONE);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (gnt0 !== 1'b1 || rvalid1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL mid_after: got gnt0=%b rv1=%b expected 1 0", gnt0, rvalid1);
      end
      step();
      set_req0(1'b0, 0, 0, WE_NONE);
      @(negedge clk);
      total++;
      if (rvalid0 !== 1'b1 || rdata0 !== 32'hA5000008 || rvalid1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL mid_rsp0: got rv0=%b rd0=%h rv1=%b expected 1 a5000008 0", rvalid0, rdata0, rvalid1);
      end
      step();
   endtask

   task automatic test_idle();
      set_req0(1'b0, 0, 0, WE_NONE);
      set_req1(1'b0, 0, 0, WE_NONE);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (mem_en !== 1'b0 || mem_addr !== '0 || mem_we !== 4'h0 || mem_d !== 32'h0 ||
             rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle[%0d]: got en=%b addr=%h we=%b d=%h rv=%b%b expected all 0",
                     i, mem_en, mem_addr, mem_we, mem_d, rvalid1, rvalid0);
         end
         step();
      end
      set_req1(1'b1, 50, 0, WE_NONE);
      @(negedge clk);
      total++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL idle_lone_req1: got %b%b expected 10", gnt1, gnt0);
      end
      step();
      set_req1(1'b0, 0, 0, WE_NONE);
      step();
      step();
   endtask

   initial begin
      test_reset();
      test_first_contention();
      test_round_robin();
      test_write();
      test_saturation();
      test_reset_mid();
      test_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
